// File: rtl/lsu_pkg.sv
// lsu_pkg: op encodings, FSM states and access helpers for the load/store stage
package lsu_pkg;
  localparam logic [2:0] OP_LB = 3'b000, OP_LH = 3'b001, OP_LW = 3'b010, OP_LBU = 3'b100, OP_LHU = 3'b101;
  localparam logic [2:0] OP_SB = 3'b000, OP_SH = 3'b001, OP_SW = 3'b010;
  typedef enum logic {IDLE, SPLIT} state_t;
  function automatic logic [2:0] op_size(input logic [2:0] op);
    return op[1:0] == 2'b00 ? 3'd1 : op[1:0] == 2'b01 ? 3'd2 : 3'd4;
  endfunction
  function automatic logic op_legal(input logic is_store, input logic [2:0] op);
    return is_store ? (op == OP_SB || op == OP_SH || op == OP_SW)
                    : (op == OP_LB || op == OP_LH || op == OP_LW || op == OP_LBU || op == OP_LHU);
  endfunction
endpackage

// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: load/store sequencer that splits misaligned SH/SW into byte stores
module lsu_mem_stage
  import lsu_pkg::*;
#(
  parameter int MEM_SIZE_KB = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        mem_write_en,
  output logic [2:0]  mem_write_op,
  output logic [31:0] mem_write_data,
  output logic [31:0] mem_write_addr,
  output logic        mem_read_en,
  output logic [2:0]  mem_read_op,
  output logic [31:0] mem_read_addr,
  input  logic [31:0] mem_read_data,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_fault
);
  localparam logic [32:0] MEM_DEPTH = 33'(MEM_SIZE_KB * 1024);
  state_t state, state_n;
  logic [1:0] cnt, idx;
  logic [31:0] addr_q, data_q;
  logic fault, misal, acc, last;
  assign fault = !op_legal(req_is_store, req_op) ||
                 ({1'b0, req_addr} + {30'b0, op_size(req_op)} > MEM_DEPTH);
  assign misal = req_is_store && ((req_op[1:0] == 2'b01 && req_addr[0]) ||
                                  (req_op[1:0] == 2'b10 && req_addr[1:0] != 2'b00));
  assign acc = state == IDLE && req_valid;
  assign last = state == SPLIT && cnt == 2'd1;
  assign req_ready = state == IDLE;
  always_comb begin
    state_n = state;
    mem_write_en = 1'b0;
    mem_write_op = '0;
    mem_write_addr = '0;
    mem_write_data = '0;
    mem_read_en = 1'b0;
    mem_read_op = '0;
    mem_read_addr = '0;
    if (state == SPLIT) begin
      mem_write_en = 1'b1;
      mem_write_op = OP_SB;
      mem_write_addr = addr_q + {30'b0, idx};
      mem_write_data = {24'b0, data_q[{idx, 3'b000} +: 8]};
      state_n = last ? IDLE : SPLIT;
    end else if (req_valid && !fault) begin
      if (!req_is_store) begin
        mem_read_en = 1'b1;
        mem_read_op = req_op;
        mem_read_addr = req_addr;
      end else begin
        mem_write_en = 1'b1;
        mem_write_op = misal ? OP_SB : req_op;
        mem_write_addr = req_addr;
        mem_write_data = misal ? {24'b0, req_wdata[7:0]} : req_wdata;
        state_n = misal ? SPLIT : IDLE;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  // byte 0 goes out on the accept cycle; the split registers carry the rest
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
      addr_q <= '0;
      data_q <= '0;
    end else if (acc && !fault && misal) begin
      cnt <= req_op[1:0] == 2'b01 ? 2'd1 : 2'd3;
      idx <= 2'd1;
      addr_q <= req_addr;
      data_q <= req_wdata;
    end else if (state == SPLIT) begin
      cnt <= cnt - 2'd1;
      idx <= idx + 2'd1;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_data <= '0;
      resp_fault <= 1'b0;
    end else begin
      resp_valid <= (acc && (fault || !misal)) || last;
      resp_data <= (acc && !fault && !req_is_store) ? mem_read_data : '0;
      resp_fault <= acc && fault;
    end
endmodule
